// File: rtl/fifo_scoreboard.sv
// fifo_scoreboard: golden circular-queue checker for a single-clock FIFO.
// Watches push/pop handshakes and DUT flags, compares popped data against the
// queue head, and counts matches and mismatches with saturating counters.
// Flags overflow and underflow as sticky bits. Can optionally halt on the
// first data error.
// Define SCB_DISPLAY_EN to print push, compare and error events in simulation.
// The hardware is the same whether or not that macro is defined.
module fifo_scoreboard #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int RD_LAT      = 0,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0,
  parameter int FLAG_STRICT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_en,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_en,
  input  logic [WIDTH-1:0]         pop_data,
  input  logic                     dut_full,
  input  logic                     dut_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         exp_data,
  output logic                     err_pulse,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic                     overflow,
  output logic                     underflow,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HALT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wptr, rptr, level_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head, cmp_exp;
  logic             run, q_empty, q_full;
  logic             push_acc, pop_acc, do_push, do_pop, ovf_ev, unf_ev;
  logic             cmp_vld, data_ok, data_bad, flag_bad;

  // Add up to two events to a counter and stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign level   = wptr - rptr;
  assign q_empty = (level == '0);
  assign q_full  = (level == FULL_LVL);
  assign head    = mem[rptr[AW-1:0]];

  // The DUT flags decide what was accepted. The golden level decides whether
  // the accepted operation was legal. A pop at full frees the slot that a
  // simultaneous push needs.
  assign push_acc = push_en & ~dut_full;
  assign pop_acc  = pop_en & ~dut_empty;
  assign do_pop   = run & pop_acc & ~q_empty;
  assign unf_ev   = run & pop_acc & q_empty;
  assign do_push  = run & push_acc & (~q_full | do_pop);
  assign ovf_ev   = run & push_acc & q_full & ~do_pop;
  assign flag_bad = run & (FLAG_STRICT != 0) &
                    ((dut_empty != q_empty) | (dut_full != q_full));

  assign level_nxt = level + (AW+1)'(do_push) - (AW+1)'(do_pop);

  generate
    if (RD_LAT == 0) begin : g_lat0
      // Compare in the same cycle as the pop. exp_data reads 0 while the queue is empty.
      assign cmp_vld  = do_pop;
      assign cmp_exp  = head;
      assign exp_data = q_empty ? '0 : head;
    end else begin : g_lat1
      logic             pend_vld;
      logic [WIDTH-1:0] exp_q;
      // Latch the head on a pop and compare it against the DUT data one cycle later.
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_vld <= 1'b0;
          exp_q    <= '0;
        end else if (run) begin
          pend_vld <= do_pop;
          if (do_pop) exp_q <= head;
        end
      end
      assign cmp_vld  = pend_vld & run;
      assign cmp_exp  = exp_q;
      assign exp_data = exp_q;
    end
  endgenerate

  assign data_ok  = cmp_vld & (pop_data == cmp_exp);
  assign data_bad = cmp_vld & (pop_data != cmp_exp);

  // Advance the queue pointers. The extra wrap bit tells full apart from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Write accepted words into the golden queue storage.
  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  // Update the counters, sticky error bits and the registered error pulse.
  // Every event is gated by run, so HALT freezes all of them.
  // The pulse for the mismatch that causes HALT is still shown for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      match_cnt    <= sat_add(match_cnt, {1'b0, data_ok});
      mismatch_cnt <= sat_add(mismatch_cnt, 2'(data_bad) + 2'(flag_bad));
      if (ovf_ev) overflow  <= 1'b1;
      if (unf_ev) underflow <= 1'b1;
      err_pulse    <= data_bad | flag_bad | ovf_ev | unf_ev;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: become ACTIVE on traffic, return to IDLE when drained, and
  // optionally stop on a data error.
  // NOTE: assign a default at the top of every combinational block so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if ((STOP_ON_ERR != 0) && data_bad) state_d = HALT;
        else if (push_acc)                  state_d = ACTIVE;
      end
      ACTIVE: begin
        if ((STOP_ON_ERR != 0) && data_bad)     state_d = HALT;
        else if (do_pop && (level_nxt == '0))   state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    state = state_q;
    run   = (state_q != HALT);
  end

`ifdef SCB_DISPLAY_EN
  // Simulation trace of scoreboard events.
  always @(posedge clk) begin
    if (rst_n) begin
      if (do_push)  $display("PUSH: %h", push_data);
      if (data_ok)  $display("PASS exp %h got %h @%0t", cmp_exp, pop_data, $time);
      if (data_bad) $display("FAIL exp %h got %h @%0t", cmp_exp, pop_data, $time);
      if (ovf_ev)   $display("OVERFLOW: %h dropped @%0t", push_data, $time);
      if (unf_ev)   $display("UNDERFLOW @%0t", $time);
      if (flag_bad) $display("FLAG ERROR: full %b empty %b level %0d @%0t",
                             dut_full, dut_empty, level, $time);
    end
  end
`endif

endmodule

// File: doc/fifo_scoreboard.md
Name: fifo_scoreboard

Overview:
- Single-clock, parametrised scoreboard that checks any FIFO DUT against a golden circular queue.
- Observes push/pop handshakes and DUT flags, then compares popped data against the queue head.
- Counts matches and mismatches, flags overflow and underflow, and optionally halts on the first error.
- Synthesisable, so it can sit in a testbench or on an FPGA debug fabric beside a FIFO instance.

Parameters:
- WIDTH, 8, data width of pushed/popped words.
- DEPTH, 16, golden queue capacity (power of 2, ≥2); must equal the DUT depth.
- RD_LAT, 0, DUT read latency. 0 = pop_data valid in the same cycle as pop_en. 1 = pop_data valid the cycle after.
- CNT_W, 16, width of the match and mismatch counters.
- STOP_ON_ERR, 0, 1 = enter HALT on the first data mismatch.
- FLAG_STRICT, 0, 1 = check dut_full/dut_empty against the golden level every cycle.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- push_en  in  1  DUT write request.
- push_data  in  WIDTH  DUT write data.
- pop_en  in  1  DUT read request.
- pop_data  in  WIDTH  DUT read data.
- dut_full  in  1  DUT full flag.
- dut_empty  in  1  DUT empty flag.
- level  out  $clog2(DEPTH)+1  golden occupancy.
- exp_data  out  WIDTH  expected word for the current/pending compare.
- err_pulse  out  1  one-cycle pulse per error event.
- match_cnt  out  CNT_W  successful compares.
- mismatch_cnt  out  CNT_W  failed data compares plus flag errors.
- overflow  out  1  sticky.
- underflow  out  1  sticky.
- state  out  2  0=IDLE, 1=ACTIVE, 2=HALT.

Behaviour:
- Reset (async assert, sync release): queue pointers and level = 0; counters, overflow, underflow, err_pulse and exp_data = 0; state = IDLE; any pending RD_LAT=1 compare is discarded. A mid-operation reset clears all of this immediately.
- Pointers: wptr/rptr are $clog2(DEPTH)+1 bits wide (extra wrap bit); level = wptr − rptr. They wrap modulo 2·DEPTH.
- Accepted push = push_en && !dut_full. The word is written at wptr and wptr is incremented.
- Overflow: if level == DEPTH at an accepted push, set overflow and pulse err_pulse. Drop the word and leave wptr unchanged.
- Accepted pop = pop_en && !dut_empty.
- Underflow: if level == 0 at an accepted pop, set underflow, pulse err_pulse and skip the compare. rptr is unchanged.
- Compare, RD_LAT=0: pop_data is compared to the head in the same cycle. exp_data = head combinationally.
- Compare, RD_LAT=1: the head is registered into exp_data, and pop_data is compared on the next clock edge.
- Compare result: match increments match_cnt; mismatch increments mismatch_cnt and pulses err_pulse (registered, one cycle).
- Simultaneous accepted push and pop: pop takes the old head and level is unchanged. At level == DEPTH both proceed (no overflow); at level == 0 underflow applies to the pop and the push still lands.
- FLAG_STRICT=1: each cycle, (dut_empty != (level==0)) or (dut_full != (level==DEPTH)) counts one mismatch_cnt and one err_pulse. Both flags wrong in the same cycle still count as one event.
- FLAG_STRICT=0: the DUT flags only gate acceptance.
- Counters saturate at all-ones and never wrap. Several error events in one cycle add their sum, saturating.
- State machine:
  - IDLE → ACTIVE on an accepted push.
  - ACTIVE → IDLE when level reaches 0 after a pop.
  - IDLE/ACTIVE → HALT on a data mismatch when STOP_ON_ERR=1.
  - HALT freezes the queue, counters and exp_data, and holds err_pulse at 0. It exits only via rst_n.

Optional Feature:
- SCB_DISPLAY_EN defined: $display each accepted push ("PUSH: %h"), each compare ("PASS exp %h got %h" / "FAIL exp %h got %h" with $time), and each overflow/underflow/flag event.
- Undefined: no simulation prints; hardware behaviour is identical.

Test Plan:
- DEPTH=16, RD_LAT=0, push 1..16 with pop_en low, dut_full=1 after the 16th push; then pop 16 → level peaks at 16 then returns to 0, match_cnt=16, mismatch_cnt=0, state ACTIVE→IDLE.
- RD_LAT=1, push 8'hA5, 8'h3C; pop twice, DUT returns 8'hA5, 8'h00 one cycle late → match_cnt=1, mismatch_cnt=1, err_pulse high for exactly one cycle.
- Level=16, push_en=1 with dut_full=0 erroneously → overflow=1, level stays 16. With FLAG_STRICT=1, mismatch_cnt also increments once per cycle while the flag stays wrong.
- Level=0, pop_en=1 with dut_empty=0 → underflow=1, no compare, match_cnt unchanged.
- STOP_ON_ERR=1, push 1,2,3, DUT pops 1,9,3 → HALT after the 2nd pop, match_cnt=1, mismatch_cnt=1 frozen; assert rst_n low mid-stream → all outputs 0 and state=IDLE immediately.
- Level=4, simultaneous push 8'h77 and pop for 8 cycles → level stays 4, wptr and rptr wrap past DEPTH, all compares match.
